// File: rtl/edge_arb_pkg.sv
// edge_arb_pkg: shared types and constants for the edge-triggered round-robin
// arbiter.
//
// Contents:
//   arb_state_t          - arbiter state (IDLE / GRANT / GAP), 2-bit encoding
//   N_REQ_DEF, HOLD_W_DEF - default requester count and hold_len width
//   idx_width()          - width of a requester index (at least 1 bit)
package edge_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_GAP   = 2'd2
    } arb_state_t;

    localparam int N_REQ_DEF  = 4;
    localparam int HOLD_W_DEF = 2;

    // A single requester still needs a 1-bit index so that port widths stay legal.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/edge_req_arbiter_rr_pick.sv
// rr_pick: combinational round-robin selector.
//
// Searches the pending vector starting one position after last_idx and
// wrapping modulo N_REQ. The first pending requester found wins.
//
// Ports:
//   pend          (in,  N_REQ) registered pending-request bits
//   last_idx      (in,  IDX_W) index of the most recent grantee
//   valid         (out, 1)     at least one request is pending
//   winner_idx    (out, IDX_W) index of the selected requester
//   winner_onehot (out, N_REQ) one-hot form of winner_idx; zero when !valid
//
// Handshake: valid qualifies winner_idx and winner_onehot. There is no ready
// signal. The consumer takes the winner only on a cycle it chooses (IDLE with
// valid high). Holding the winner costs nothing because the selector is
// purely combinational.
module rr_pick
    import edge_arb_pkg::*;
#(
    parameter int N_REQ = N_REQ_DEF,
    localparam int IDX_W = idx_width(N_REQ)
) (
    input  logic [N_REQ-1:0] pend,
    input  logic [IDX_W-1:0] last_idx,
    output logic             valid,
    output logic [IDX_W-1:0] winner_idx,
    output logic [N_REQ-1:0] winner_onehot
);

    logic [IDX_W-1:0] cand;

    // Walk the offsets from farthest to nearest. The nearest pending
    // candidate is written last, so it ends up holding the result.
    always_comb begin
        valid      = 1'b0;
        winner_idx = '0;
        cand       = '0;
        for (int k = N_REQ; k >= 1; k--) begin
            cand = IDX_W'((int'(last_idx) + k) % N_REQ);
            if (pend[cand]) begin
                valid      = 1'b1;
                winner_idx = cand;
            end
        end
        winner_onehot = valid ? (N_REQ'(1) << winner_idx) : '0;
    end

endmodule

// File: rtl/edge_req_arbiter.sv
// edge_req_arbiter: round-robin arbiter that shares one timed grant slot among
// N_REQ requesters.
//
// A rising edge on req_in[i] latches a pending bit. The FSM then grants one
// requester at a time for hold_len+1 cycles. Every grant is followed by one
// dead GAP cycle.
//
// Ports:
//   clock     (in,  1)      rising-edge clock
//   rst_n     (in,  1)      asynchronous active-low reset
//   req_in    (in,  N_REQ)  raw request levels; only rising edges matter
//   hold_len  (in,  HOLD_W) grant length minus one, sampled at grant start
//   grant     (out, N_REQ)  registered one-hot grant
//   grant_idx (out, IDX_W)  registered index of current or last grantee
//   busy      (out, 1)      registered, high in GRANT and GAP
//   pend_any  (out, 1)      registered OR of the pending bits
//
// Build option:
//   ARB_SYNC_EN - adds a two-flop synchronizer in front of the edge detector,
//                 for asynchronous request pins. Input-to-grant latency goes
//                 from 2 clocks to 4.
//
// Debug visibility: the FSM state is held in the typed signal 'state'.
module edge_req_arbiter
    import edge_arb_pkg::*;
#(
    parameter int N_REQ  = N_REQ_DEF,
    parameter int HOLD_W = HOLD_W_DEF,
    localparam int IDX_W = idx_width(N_REQ)
) (
    input  logic              clock,
    input  logic              rst_n,
    input  logic [N_REQ-1:0]  req_in,
    input  logic [HOLD_W-1:0] hold_len,
    output logic [N_REQ-1:0]  grant,
    output logic [IDX_W-1:0]  grant_idx,
    output logic              busy,
    output logic              pend_any
);

    arb_state_t        state;
    arb_state_t        state_d;

    logic [N_REQ-1:0]  req_s;
    logic [N_REQ-1:0]  req_q;
    logic [N_REQ-1:0]  req_edge;
    logic [N_REQ-1:0]  pend;
    logic [N_REQ-1:0]  pend_d;
    logic [IDX_W-1:0]  last_idx;
    logic [HOLD_W-1:0] hold_cnt;

    logic              pick_valid;
    logic [IDX_W-1:0]  pick_idx;
    logic [N_REQ-1:0]  pick_onehot;

    logic              grant_start;
    logic              hold_done;
    logic [N_REQ-1:0]  grant_d;
    logic              busy_d;

    // ------------------------------------------------------------------
    // Request conditioning
    // ------------------------------------------------------------------
`ifdef ARB_SYNC_EN
    logic [N_REQ-1:0] sync1;
    logic [N_REQ-1:0] sync2;

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= req_in;
            sync2 <= sync1;
        end
    end

    assign req_s = sync2;
`else
    assign req_s = req_in;
`endif

    // req_q resets low, so a level still high after reset counts as a fresh edge.
    assign req_edge = req_s & ~req_q;

    // ------------------------------------------------------------------
    // Round-robin selection over the registered pending bits
    // ------------------------------------------------------------------
    rr_pick #(
        .N_REQ (N_REQ)
    ) u_rr_pick (
        .pend          (pend),
        .last_idx      (last_idx),
        .valid         (pick_valid),
        .winner_idx    (pick_idx),
        .winner_onehot (pick_onehot)
    );

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state;
        case (state)
            ST_IDLE:  if (pick_valid) state_d = ST_GRANT;
            ST_GRANT: if (hold_cnt == '0) state_d = ST_GAP;
            ST_GAP:   state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: output and datapath decode (values registered below)
    // ------------------------------------------------------------------
    always_comb begin
        grant_start = (state == ST_IDLE) && pick_valid;
        hold_done   = (state == ST_GRANT) && (hold_cnt == '0);

        grant_d = '0;
        if (grant_start) begin
            grant_d = pick_onehot;
        end else if ((state == ST_GRANT) && !hold_done) begin
            grant_d = grant;
        end

        busy_d = (state_d != ST_IDLE);

        // Clear the winner's bit first and then OR in new edges. This way an
        // edge that arrives on the grant-start cycle is kept rather than lost.
        pend_d = (pend & ~(grant_start ? pick_onehot : '0)) | req_edge;
    end

    // ------------------------------------------------------------------
    // Registered datapath
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            req_q     <= '0;
            pend      <= '0;
            pend_any  <= 1'b0;
            grant     <= '0;
            grant_idx <= '0;
            busy      <= 1'b0;
            hold_cnt  <= '0;
            last_idx  <= IDX_W'(N_REQ - 1);
        end else begin
            req_q    <= req_s;
            pend     <= pend_d;
            pend_any <= |pend_d;
            grant    <= grant_d;
            busy     <= busy_d;
            if (grant_start) begin
                grant_idx <= pick_idx;
                last_idx  <= pick_idx;
                hold_cnt  <= hold_len;
            end else if ((state == ST_GRANT) && (hold_cnt != '0)) begin
                hold_cnt <= hold_cnt - HOLD_W'(1);
            end
        end
    end

endmodule
